text_entry_buffer: RTL
======================

TEXT_ENTRY_BUFFER -- requirements
Module: text_entry_buffer

Interface
REQ-001 SHALL have parameter TEXT_LEN_MAX, default 20, maximum characters stored (range 1..63).
REQ-002 SHALL have parameter LETTER_W, default 5, width of one letter code.
REQ-003 SHALL have port clock_27mhz  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port entry_en  input  1  level; high enables a text-entry session.
REQ-006 SHALL have port button_enter  input  1  debounced level; high commits the session.
REQ-007 SHALL have port scan_code  input  8  PS/2 make code from keyboard decoder.
REQ-008 SHALL have port scan_valid  input  1  one-cycle strobe qualifying scan_code.
REQ-009 SHALL have port letter_array  output  TEXT_LEN_MAX*LETTER_W  letter codes; first typed character in the most-significant slot.
REQ-010 SHALL have port char_count  output  6  number of valid characters stored.
REQ-011 SHALL have port accepting  output  1  high while in EDIT.
REQ-012 SHALL have port array_rdy  output  1  high when letter_array is stable (IDLE or DONE).
REQ-013 SHALL have port overflow  output  1  sticky; a character arrived while the buffer was full.

Function
REQ-014 SHALL implement FSM states IDLE, EDIT, DONE.
REQ-015 IDLE->EDIT when entry_en=1: same edge fills all slots with 26 (blank), clears char_count and overflow.
REQ-016 EDIT->DONE when button_enter=1; EDIT->IDLE when entry_en=0, contents retained.
REQ-017 DONE->IDLE when entry_en=0; button_enter held in DONE has no effect.
REQ-018 In EDIT, scan_valid with a mapped code SHALL write the code to slot TEXT_LEN_MAX-1-char_count and increment char_count; visible one cycle after the strobe.
REQ-019 Map: A..Z make codes (1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A) -> 0..25; 29 (space) -> 26.
REQ-020 Unmapped codes other than backspace (66) SHALL be ignored: no write, no count change.
REQ-021 Full (char_count=TEXT_LEN_MAX): mapped code dropped, overflow set; count never exceeds TEXT_LEN_MAX.
REQ-022 scan_valid and button_enter on the same edge: enter wins, character dropped.
REQ-023 scan_valid outside EDIT SHALL be ignored.
REQ-024 accepting=1 only in EDIT; array_rdy=~accepting.

Reset
REQ-025 Reset SHALL force IDLE, char_count=0, overflow=0, all slots=26, accepting=0, array_rdy=1, independent of clock, including mid-session.

Configuration
REQ-026 With TEXT_ENTRY_BACKSPACE_EN defined, code 66 in EDIT with char_count>0 SHALL write 26 to slot TEXT_LEN_MAX-char_count, decrement char_count, and leave overflow unchanged; at char_count=0 no-op.
REQ-027 Without TEXT_ENTRY_BACKSPACE_EN, code 66 SHALL be treated as unmapped (ignored).

Structure
REQ-028 Letter constants (LETTER_SPACE=26, SC_BACKSPACE=8'h66) and FSM state encodings SHALL reside in the shared param.v package.
REQ-029 Scan-code-to-letter mapping SHALL be a combinational sub-module scan2letter (outputs letter, valid flag).

Verification
REQ-030 Reset, entry_en=1, type 33,24,4B,4B,44 ("HELLO") -> char_count=5, top five slots 7,4,11,11,14, rest 26, accepting=1.
REQ-031 TEXT_LEN_MAX=4, type 5 letters -> char_count=4, fifth dropped, overflow=1; re-enter EDIT -> overflow=0, slots all 26.
REQ-032 Backspace build: type 1C,32, then 66 -> char_count=1, slot TEXT_LEN_MAX-2=26; 66 at count 0 -> no change.
REQ-033 scan_valid(1C) coincident with button_enter -> state DONE, char_count unchanged, array_rdy=1 next cycle.
REQ-034 Assert reset mid-EDIT with 3 chars stored, no clock edge -> outputs immediately at reset values.
REQ-035 Code 0x05 (F1) in EDIT and 0x1C in IDLE -> both ignored, char_count unchanged.

Source files
------------

// File: rtl/text_entry_buffer_pkg.sv
// Shared constants for the text entry buffer: letter codes, keyboard codes
// and FSM state encodings.
package text_entry_buffer_pkg;

   localparam int         LETTER_SPACE = 26;
   localparam logic [7:0] SC_BACKSPACE = 8'h66;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EDIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/scan2letter.sv
// Combinational PS/2 make code to letter translator: A..Z -> 0..25, space -> 26.
module scan2letter #(
   parameter int LETTER_W = 5
) (
   input  logic [7:0]          scan_code,
   output logic [LETTER_W-1:0] letter,
   output logic                letter_valid
);

   logic [4:0] code_raw;

   always_comb begin
      code_raw     = 5'd0;
      letter_valid = 1'b1;
      case (scan_code)
         8'h1C: code_raw = 5'd0;
         8'h32: code_raw = 5'd1;
         8'h21: code_raw = 5'd2;
         8'h23: code_raw = 5'd3;
         8'h24: code_raw = 5'd4;
         8'h2B: code_raw = 5'd5;
         8'h34: code_raw = 5'd6;
         8'h33: code_raw = 5'd7;
         8'h43: code_raw = 5'd8;
         8'h3B: code_raw = 5'd9;
         8'h42: code_raw = 5'd10;
         8'h4B: code_raw = 5'd11;
         8'h3A: code_raw = 5'd12;
         8'h31: code_raw = 5'd13;
         8'h44: code_raw = 5'd14;
         8'h4D: code_raw = 5'd15;
         8'h15: code_raw = 5'd16;
         8'h2D: code_raw = 5'd17;
         8'h1B: code_raw = 5'd18;
         8'h2C: code_raw = 5'd19;
         8'h3C: code_raw = 5'd20;
         8'h2A: code_raw = 5'd21;
         8'h1D: code_raw = 5'd22;
         8'h22: code_raw = 5'd23;
         8'h35: code_raw = 5'd24;
         8'h1A: code_raw = 5'd25;
         8'h29: code_raw = 5'd26;
         default: letter_valid = 1'b0;
      endcase
   end

   assign letter = LETTER_W'(code_raw);

endmodule

// File: rtl/text_entry_buffer.sv
// Keyboard text entry buffer: collects mapped letters during an EDIT session.
// Optional build macro TEXT_ENTRY_BACKSPACE_EN enables backspace editing.
module text_entry_buffer
   import text_entry_buffer_pkg::*;
#(
   parameter int TEXT_LEN_MAX = 20,
   parameter int LETTER_W     = 5
) (
   input  logic                             clock_27mhz,
   input  logic                             reset,
   input  logic                             entry_en,
   input  logic                             button_enter,
   input  logic [7:0]                       scan_code,
   input  logic                             scan_valid,
   output logic [TEXT_LEN_MAX*LETTER_W-1:0] letter_array,
   output logic [5:0]                       char_count,
   output logic                             accepting,
   output logic                             array_rdy,
   output logic                             overflow
);

   localparam logic [LETTER_W-1:0] BLANK = LETTER_W'(LETTER_SPACE);

   state_t              state_reg, state_next;
   logic [5:0]          count_reg;
   logic                overflow_reg;
   logic [LETTER_W-1:0] slot_reg [TEXT_LEN_MAX];

   logic [LETTER_W-1:0] map_letter;
   logic                map_valid;
   logic                clear_en, wr_en, bs_en, ovf_set;
   logic                full;
   logic [5:0]          wr_idx, bs_idx;

   scan2letter #(.LETTER_W(LETTER_W)) u_scan2letter (
      .scan_code    (scan_code),
      .letter       (map_letter),
      .letter_valid (map_valid)
   );

   assign full   = (count_reg == 6'(TEXT_LEN_MAX));
   // First character lands in the most-significant slot and fills downward.
   assign wr_idx = 6'(TEXT_LEN_MAX - 1) - count_reg;
   assign bs_idx = 6'(TEXT_LEN_MAX) - count_reg;

   always_ff @(posedge clock_27mhz or posedge reset) begin
      if (reset) state_reg <= ST_IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      clear_en   = 1'b0;
      wr_en      = 1'b0;
      bs_en      = 1'b0;
      ovf_set    = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (entry_en) begin
               state_next = ST_EDIT;
               clear_en   = 1'b1;
            end
         end
         ST_EDIT: begin
            // Enter takes priority; a coincident keystroke is dropped.
            if (button_enter) begin
               state_next = ST_DONE;
            end else if (!entry_en) begin
               state_next = ST_IDLE;
            end else if (scan_valid) begin
               if (map_valid) begin
                  if (full) ovf_set = 1'b1;
                  else      wr_en   = 1'b1;
               end
`ifdef TEXT_ENTRY_BACKSPACE_EN
               else if (scan_code == SC_BACKSPACE && count_reg != 6'd0) begin
                  bs_en = 1'b1;
               end
`endif
            end
         end
         ST_DONE: begin
            if (!entry_en) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock_27mhz or posedge reset) begin
      if (reset) begin
         count_reg    <= 6'd0;
         overflow_reg <= 1'b0;
      end else if (clear_en) begin
         count_reg    <= 6'd0;
         overflow_reg <= 1'b0;
      end else begin
         if (wr_en)   count_reg    <= count_reg + 6'd1;
         if (bs_en)   count_reg    <= count_reg - 6'd1;
         if (ovf_set) overflow_reg <= 1'b1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < TEXT_LEN_MAX; gi++) begin : g_slot
         always_ff @(posedge clock_27mhz or posedge reset) begin
            if (reset)                               slot_reg[gi] <= BLANK;
            else if (clear_en)                       slot_reg[gi] <= BLANK;
            else if (wr_en && wr_idx == 6'(gi))      slot_reg[gi] <= map_letter;
            else if (bs_en && bs_idx == 6'(gi))      slot_reg[gi] <= BLANK;
         end
         assign letter_array[gi*LETTER_W +: LETTER_W] = slot_reg[gi];
      end
   endgenerate

   assign char_count = count_reg;
   assign overflow   = overflow_reg;
   assign accepting  = (state_reg == ST_EDIT);
   assign array_rdy  = ~accepting;

endmodule
